// File: rtl/i2s_in_arb.sv
// Round-robin merge of per-port i2s_in sample streams into one back-pressurable AXI stream.
// Optional build macro I2S_IN_ARB_DROP_CNT_EN adds per-port saturating drop counters.
module i2s_in_arb #(
  parameter int unsigned PORTS      = 16,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [PORTS-1:0]              s_axis_tvalid,
  input  logic [PORTS*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [PORTS-1:0]              s_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tlast,
  output logic [$clog2(PORTS)-1:0]      m_axis_tid,
  output logic [3:0]                    m_axis_tdest,
  input  logic [PORTS-1:0]              i_enable,
  input  logic [4*PORTS-1:0]            i_dst_fpga_index,
  input  logic                          i_clear,
  output logic [PORTS-1:0]              o_overflow,
  input  logic [$clog2(PORTS)-1:0]      i_cnt_sel,
  output logic [7:0]                    o_drop_cnt
);

  localparam int unsigned IDW = $clog2(PORTS);

  logic [DATA_WIDTH:0]   r_mem [PORTS][2];
  logic [1:0]            r_cnt [PORTS];
  logic [IDW-1:0]        r_rr;
  logic                  r_ovalid;
  logic [DATA_WIDTH-1:0] r_odata;
  logic                  r_olast;
  logic [IDW-1:0]        r_otid;
  logic [3:0]            r_odest;
  logic [PORTS-1:0]      r_ovf;

  logic [PORTS-1:0]      w_push;
  logic [PORTS-1:0]      w_pop;
  logic [PORTS-1:0]      w_drop;
  logic [PORTS-1:0]      w_acc;
  logic                  w_found;
  logic                  w_load;
  logic [IDW-1:0]        w_win;
  logic [IDW-1:0]        w_idx;

  // First eligible port at or after the round-robin pointer.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int unsigned k = 0; k < PORTS; k++) begin
      w_idx = r_rr + IDW'(k);
      if (!w_found && (r_cnt[w_idx] != 2'd0) && i_enable[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_load = w_found & (~r_ovalid | m_axis_tready);

  always_comb begin
    w_push = '0;
    w_pop  = '0;
    w_drop = '0;
    w_acc  = '0;
    for (int unsigned p = 0; p < PORTS; p++) begin
      w_push[p] = s_axis_tvalid[p] & i_enable[p];
      w_pop[p]  = w_load && (w_win == IDW'(p));
      w_drop[p] = w_push[p] && (r_cnt[p] == 2'd2) && !w_pop[p];
      w_acc[p]  = w_push[p] && !w_drop[p];
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned p = 0; p < PORTS; p++) begin
      if (reset || !i_enable[p]) begin
        r_cnt[p] <= 2'd0;
      end else begin
        r_cnt[p] <= r_cnt[p] + {1'b0, w_acc[p]} - {1'b0, w_pop[p]};
      end
    end
  end

  // Shift FIFO with entry 0 as head; on pop+push the later write to entry 0 wins when count is 1.
  always_ff @(posedge clk) begin
    for (int unsigned p = 0; p < PORTS; p++) begin
      if (w_pop[p]) begin
        r_mem[p][0] <= r_mem[p][1];
        if (w_acc[p]) begin
          if (r_cnt[p] == 2'd2) begin
            r_mem[p][1] <= {s_axis_tlast[p], s_axis_tdata[p*DATA_WIDTH +: DATA_WIDTH]};
          end else begin
            r_mem[p][0] <= {s_axis_tlast[p], s_axis_tdata[p*DATA_WIDTH +: DATA_WIDTH]};
          end
        end
      end else if (w_acc[p]) begin
        r_mem[p][r_cnt[p][0]] <= {s_axis_tlast[p], s_axis_tdata[p*DATA_WIDTH +: DATA_WIDTH]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovalid <= 1'b0;
      r_odata  <= '0;
      r_olast  <= 1'b0;
      r_otid   <= '0;
      r_odest  <= '0;
      r_rr     <= '0;
    end else begin
      if (w_load) begin
        r_ovalid <= 1'b1;
        r_odata  <= r_mem[w_win][0][DATA_WIDTH-1:0];
        r_olast  <= r_mem[w_win][0][DATA_WIDTH];
        r_otid   <= w_win;
        r_odest  <= i_dst_fpga_index[4*w_win +: 4];
        r_rr     <= w_win + 1'b1;
      end else if (m_axis_tready) begin
        r_ovalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_ovf <= '0;
    end else begin
      r_ovf <= r_ovf | w_drop;
    end
  end

`ifdef I2S_IN_ARB_DROP_CNT_EN
  logic [7:0] r_drop [PORTS];

  always_ff @(posedge clk) begin
    for (int unsigned p = 0; p < PORTS; p++) begin
      if (reset || i_clear) begin
        r_drop[p] <= '0;
      end else if (w_drop[p] && (r_drop[p] != 8'hFF)) begin
        r_drop[p] <= r_drop[p] + 8'd1;
      end
    end
  end

  assign o_drop_cnt = r_drop[i_cnt_sel];
`else
  logic w_unused_cnt_sel;
  assign w_unused_cnt_sel = ^i_cnt_sel;
  assign o_drop_cnt       = '0;
`endif

  assign m_axis_tvalid = r_ovalid;
  assign m_axis_tdata  = r_odata;
  assign m_axis_tlast  = r_olast;
  assign m_axis_tid    = r_otid;
  assign m_axis_tdest  = r_odest;
  assign o_overflow    = r_ovf;

endmodule

// File: tb/tb_i2s_in_arb.sv
// Scoreboard bench for i2s_in_arb: expected words queued at stimulus, compared on each handshake.
module tb_i2s_in_arb;

  localparam int P  = 16;
  localparam int DW = 32;

`ifdef I2S_IN_ARB_DROP_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic [P-1:0]  s_axis_tvalid;
  logic [P*DW-1:0] s_axis_tdata;
  logic [P-1:0]  s_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic [3:0]    m_axis_tid;
  logic [3:0]    m_axis_tdest;
  logic [P-1:0]  i_enable;
  logic [4*P-1:0] i_dst_fpga_index;
  logic          i_clear;
  logic [P-1:0]  o_overflow;
  logic [3:0]    i_cnt_sel;
  logic [7:0]    o_drop_cnt;

  i2s_in_arb #(.PORTS(P), .DATA_WIDTH(DW)) dut (
    .clk              (clk),
    .reset            (reset),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tlast     (s_axis_tlast),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tlast     (m_axis_tlast),
    .m_axis_tid       (m_axis_tid),
    .m_axis_tdest     (m_axis_tdest),
    .i_enable         (i_enable),
    .i_dst_fpga_index (i_dst_fpga_index),
    .i_clear          (i_clear),
    .o_overflow       (o_overflow),
    .i_cnt_sel        (i_cnt_sel),
    .o_drop_cnt       (o_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [40:0] sb[$];
  logic [40:0] mon_exp;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && m_axis_tvalid && m_axis_tready) begin
      check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        mon_exp = sb.pop_front();
        check("sb_word", 64'({m_axis_tlast, m_axis_tid, m_axis_tdest, m_axis_tdata}), 64'(mon_exp));
      end
    end
  end

  function automatic logic [3:0] dest_of(input int p);
    return 4'(15 - p);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    s_axis_tdata  = '0;
  endtask

  task automatic drive(input int p, input logic [31:0] d, input logic l);
    s_axis_tvalid[p]          = 1'b1;
    s_axis_tdata[p*DW +: DW]  = d;
    s_axis_tlast[p]           = l;
  endtask

  task automatic expect_w(input int p, input logic [31:0] d, input logic l);
    sb.push_back({l, 4'(p), dest_of(p), d});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clr_in();
    tick();
    tick();
    reset = 1'b0;
  endtask

  logic [31:0] w [4];
  logic [31:0] d0;
  logic [31:0] d1;

  initial begin
    reset         = 1'b1;
    m_axis_tready = 1'b1;
    i_enable      = '1;
    i_clear       = 1'b0;
    i_cnt_sel     = '0;
    clr_in();
    for (int p = 0; p < P; p++) i_dst_fpga_index[4*p +: 4] = dest_of(p);
    repeat (3) tick();

    check("rst_valid", 64'(m_axis_tvalid), 64'd0);
    check("rst_data",  64'(m_axis_tdata),  64'd0);
    check("rst_last",  64'(m_axis_tlast),  64'd0);
    check("rst_tid",   64'(m_axis_tid),    64'd0);
    check("rst_tdest", 64'(m_axis_tdest),  64'd0);
    check("rst_ovf",   64'(o_overflow),    64'd0);
    check("rst_cnt",   64'(o_drop_cnt),    64'd0);
    reset = 1'b0;
    tick();

    // Single word on port 5
    drive(5, 32'h12345678, 1'b1);
    expect_w(5, 32'h12345678, 1'b1);
    tick();
    clr_in();
    check("t1_not_yet", 64'(m_axis_tvalid), 64'd0);
    tick();
    check("t1_valid", 64'(m_axis_tvalid), 64'd1);
    check("t1_data",  64'(m_axis_tdata),  64'h12345678);
    check("t1_last",  64'(m_axis_tlast),  64'd1);
    check("t1_tid",   64'(m_axis_tid),    64'd5);
    check("t1_tdest", 64'(m_axis_tdest),  64'hA);
    tick();
    check("t1_once", 64'(m_axis_tvalid), 64'd0);

    // Round-robin from rr=0, then wrap from rr=8
    do_reset();
    for (int i = 0; i < 3; i++) begin
      d0 = $urandom;
      drive((i == 0) ? 0 : (i == 1) ? 3 : 7, d0, i[0]);
      expect_w((i == 0) ? 0 : (i == 1) ? 3 : 7, d0, i[0]);
    end
    tick();
    clr_in();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rr_b2b", 64'(m_axis_tvalid), 64'd1);
    end
    tick();
    check("rr_idle", 64'(m_axis_tvalid), 64'd0);
    d0 = $urandom;
    d1 = $urandom;
    drive(7, d1, 1'b0);
    drive(0, d0, 1'b1);
    expect_w(0, d0, 1'b1);
    expect_w(7, d1, 1'b0);
    tick();
    clr_in();
    tick();
    check("rr_wrap0", 64'(m_axis_tid), 64'd0);
    tick();
    check("rr_wrap7", 64'(m_axis_tid), 64'd7);
    tick();

    // Backpressure and overflow on port 2
    m_axis_tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w[i] = $urandom;
      drive(2, w[i], (i == 3));
      if (i < 3) expect_w(2, w[i], 1'b0);
      tick();
    end
    clr_in();
    i_cnt_sel = 4'd2;
    #1;
    check("ovf_flag", 64'(o_overflow), 64'h0004);
    check("ovf_cnt",  64'(o_drop_cnt), CNT_EN ? 64'd1 : 64'd0);
    check("ovf_hold_v", 64'(m_axis_tvalid), 64'd1);
    check("ovf_hold_d", 64'(m_axis_tdata),  64'(w[0]));
    m_axis_tready = 1'b1;
    repeat (4) tick();
    check("ovf_drained", 64'(m_axis_tvalid), 64'd0);
    check("ovf_sticky",  64'(o_overflow),    64'h0004);
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    check("clr_ovf", 64'(o_overflow), 64'd0);
    check("clr_cnt", 64'(o_drop_cnt), 64'd0);

    // Full FIFO with simultaneous pop on port 1
    m_axis_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      w[i] = $urandom;
      drive(1, w[i], 1'b0);
      expect_w(1, w[i], 1'b0);
      tick();
    end
    w[3] = $urandom;
    m_axis_tready = 1'b1;
    drive(1, w[3], 1'b1);
    expect_w(1, w[3], 1'b1);
    tick();
    clr_in();
    repeat (5) tick();
    i_cnt_sel = 4'd1;
    #1;
    check("fullpop_ovf", 64'(o_overflow), 64'd0);
    check("fullpop_cnt", 64'(o_drop_cnt), 64'd0);

    // Disable port 4 with a presented word and two buffered words
    m_axis_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      w[i] = $urandom;
      drive(4, w[i], 1'b0);
      tick();
    end
    expect_w(4, w[0], 1'b0);
    clr_in();
    tick();
    i_enable[4] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("dis_hold_v", 64'(m_axis_tvalid), 64'd1);
      check("dis_hold_d", 64'(m_axis_tdata),  64'(w[0]));
    end
    m_axis_tready = 1'b1;
    tick();
    check("dis_accept", 64'(m_axis_tvalid), 64'd0);
    i_enable[4] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("dis_flush", 64'(m_axis_tvalid), 64'd0);
    end

    // 300 drops on port 9, then clear coincident with a drop
    m_axis_tready = 1'b0;
    for (int i = 0; i < 303; i++) begin
      d0 = $urandom;
      drive(9, d0, 1'b0);
      if (i < 3) expect_w(9, d0, 1'b0);
      tick();
    end
    i_cnt_sel = 4'd9;
    #1;
    check("sat_ovf", 64'(o_overflow), 64'h0200);
    check("sat_cnt", 64'(o_drop_cnt), CNT_EN ? 64'd255 : 64'd0);
    i_clear = 1'b1;
    drive(9, $urandom, 1'b0);
    tick();
    i_clear = 1'b0;
    check("clrwin_ovf", 64'(o_overflow), 64'd0);
    check("clrwin_cnt", 64'(o_drop_cnt), 64'd0);
    drive(9, $urandom, 1'b0);
    tick();
    clr_in();
    check("post_clr_ovf", 64'(o_overflow), 64'h0200);
    check("post_clr_cnt", 64'(o_drop_cnt), CNT_EN ? 64'd1 : 64'd0);
    m_axis_tready = 1'b1;
    repeat (6) tick();

    check("sb_drain", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
